// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker FSM encoding and the order-to-tap table
// used by both the PRBS generator and the BER checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_t;

  // Second feedback tap for x^ORDER + x^TAP + 1; 0 flags an unsupported order.
  function automatic int prbs_tap(input int order);
    case (order)
      7:       return 6;
      15:      return 14;
      31:      return 28;
      default: return 0;
    endcase
  endfunction

  // Next PRBS bit from a history register whose MSB is the oldest bit.
  function automatic logic prbs_feedback(input logic [30:0] hist, input int order);
    return hist[order-1] ^ hist[prbs_tap(order)-1];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/prbs_ber_checker.sv
// Self-synchronising PRBS bit-error-rate checker: seeds from the line,
// verifies the seed, then counts bits and errors while locked.
module prbs_ber_checker
  import prbs_pkg::*;
#(
  parameter int PRBS_ORDER    = 31,
  parameter int CNT_WIDTH     = 32,
  parameter int LOCK_COUNT    = 64,
  parameter int UNLOCK_ERRORS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_in,
  input  logic                 data_in_valid,
  input  logic                 clear_counters,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] bit_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 err_pulse
);

  localparam int TAP     = prbs_tap(PRBS_ORDER);
  localparam int SEED_W  = $clog2(PRBS_ORDER + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

  localparam logic [SEED_W-1:0]  SEED_LAST  = SEED_W'(PRBS_ORDER - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [6:0]         UNLOCK_THR = 7'(UNLOCK_ERRORS);

  if (TAP == 0) begin : g_bad_order
    $error("prbs_ber_checker: PRBS_ORDER must be 7, 15 or 31");
  end

  prbs_state_t             state;
  logic [PRBS_ORDER-1:0]   s;
  logic [SEED_W-1:0]       seed_cnt;
  logic [MATCH_W-1:0]      match_cnt;
  logic [5:0]              win_bits;
  logic [6:0]              win_errs;

  logic predicted;
  logic bit_err;
  logic in_lock;
  logic [6:0] win_errs_next;

  assign predicted     = s[PRBS_ORDER-1] ^ s[TAP-1];
  assign bit_err       = data_in ^ predicted;
  assign in_lock       = (state == ST_LOCKED);
  assign win_errs_next = win_errs + {6'd0, bit_err};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SEED;
      s         <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= in_lock && data_in_valid && bit_err;
      if (data_in_valid) begin
        case (state)
          ST_SEED: begin
            s <= {s[PRBS_ORDER-2:0], data_in};
            if (seed_cnt == SEED_LAST) begin
              state     <= ST_VERIFY;
              seed_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              seed_cnt <= seed_cnt + 1'b1;
            end
          end
          ST_VERIFY: begin
            s <= {s[PRBS_ORDER-2:0], data_in};
            if (bit_err) begin
              state    <= ST_SEED;
              seed_cnt <= '0;
            end else if (match_cnt == MATCH_LAST) begin
              state    <= ST_LOCKED;
              locked   <= 1'b1;
              win_bits <= '0;
              win_errs <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
          ST_LOCKED: begin
            // Free-run on our own prediction so a line error is counted once.
            s        <= {s[PRBS_ORDER-2:0], predicted};
            win_bits <= win_bits + 1'b1;
            win_errs <= (win_bits == 6'd63) ? 7'd0 : win_errs_next;
            if (bit_err && (win_errs_next == UNLOCK_THR)) begin
              state    <= ST_SEED;
              locked   <= 1'b0;
              seed_cnt <= '0;
            end
          end
          default: begin
            state    <= ST_SEED;
            locked   <= 1'b0;
            seed_cnt <= '0;
          end
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_counters),
    .inc   (in_lock && data_in_valid),
    .count (bit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_err_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_counters),
    .inc   (in_lock && data_in_valid && bit_err),
    .count (err_count)
  );

endmodule

// File: doc/prbs_ber_checker.md
PRBS_BER_CHECKER -- requirements
Module: prbs_ber_checker

Interface
REQ-001 SHALL have parameter PRBS_ORDER, default 31, selecting the pattern: 7 (x^7+x^6+1), 15 (x^15+x^14+1) or 31 (x^31+x^28+1); any other value is a synthesis error.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, giving the width of the bit and error counters.
REQ-003 SHALL have parameter LOCK_COUNT, default 64, giving the number of consecutive matching bits required to declare lock.
REQ-004 SHALL have parameter UNLOCK_ERRORS, default 8, giving the error count within one 64-bit window that forces loss of lock.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port data_in, input, 1, received serial bit.
REQ-008 SHALL have port data_in_valid, input, 1, data_in qualifier; no state advances while low.
REQ-009 SHALL have port clear_counters, input, 1, single-cycle request to zero both counters.
REQ-010 SHALL have port locked, output, 1, high while in LOCKED.
REQ-011 SHALL have port bit_count, output, CNT_WIDTH, valid bits checked while locked.
REQ-012 SHALL have port err_count, output, CNT_WIDTH, mismatched bits while locked.
REQ-013 SHALL have port err_pulse, output, 1, one-cycle strobe per detected error.

Function
REQ-014 SHALL keep a PRBS_ORDER-bit state s; predicted bit p = s[ORDER-1] XOR s[TAP-1], where TAP = 6/14/28 for order 7/15/31.
REQ-015 SHALL implement FSM states SEED, VERIFY, LOCKED; each transition consumes exactly one valid bit.
REQ-016 SEED: SHALL shift data_in into s on each valid bit; after PRBS_ORDER valid bits, go to VERIFY with match counter 0.
REQ-017 VERIFY: SHALL shift data_in into s; a valid bit with data_in == p increments the match counter; data_in != p returns to SEED with bit counter 0.
REQ-018 VERIFY: when the match counter reaches LOCK_COUNT, SHALL go to LOCKED on that bit.
REQ-019 LOCKED: SHALL shift p (not data_in) into s so errors do not propagate; each valid bit increments bit_count; data_in != p increments err_count.
REQ-020 LOCKED: SHALL track errors in consecutive 64-valid-bit windows; the bit that makes a window reach UNLOCK_ERRORS SHALL return the FSM to SEED; that bit is still counted.
REQ-021 Counters SHALL saturate at all-ones and never wrap.
REQ-022 clear_counters SHALL take priority: both counters become 0 in the next cycle and any bit/error of that same cycle is not counted; FSM and window tracking are unaffected.
REQ-023 err_pulse SHALL be registered, high exactly one cycle after the clock edge sampling an erroneous valid bit in LOCKED; never in SEED or VERIFY.
REQ-024 bit_count and err_count SHALL update on the clock edge after the sampling edge (one-cycle latency); counters hold their values when lock is lost.
REQ-025 locked SHALL be registered and change on the same edge as the FSM state.

Reset
REQ-026 On rst high at a clock edge: FSM = SEED, s = 0, match/seed/window counters = 0, locked = 0, bit_count = 0, err_count = 0, err_pulse = 0.
REQ-027 rst SHALL override clear_counters and data_in_valid; reset mid-lock discards all state and re-seeding starts on the first valid bit after release.

Structure
REQ-028 PRBS order/tap table and FSM state encoding SHALL live in a shared package (prbs_pkg) reused by the prbs generator.
REQ-029 The saturating counter with clear SHALL be one sub-module, sat_counter, instantiated twice.

Verification
REQ-030 PRBS_ORDER=7, clean PRBS7 with valid always high -> locked rises after 7+64 = 71 valid bits; err_count stays 0; bit_count increments by 1 per cycle.
REQ-031 Locked PRBS31, invert one bit -> err_pulse high for exactly 1 cycle, err_count = 1, locked stays 1, next bit predicted correctly (no error multiplication).
REQ-032 Locked, invert 8 bits inside one 64-bit window (default) -> err_count = 8, locked falls on the 8th error, re-locks after 31+64 clean valid bits.
REQ-033 CNT_WIDTH=4, locked, 20 clean bits -> bit_count holds at 15; clear_counters pulse -> both counters 0, next bit -> bit_count = 1.
REQ-034 clear_counters asserted in the same cycle as an erroneous bit -> err_count = 0 afterwards, err_pulse still 1.
REQ-035 data_in_valid toggled 50% during lock acquisition -> lock after 95 valid bits (PRBS31) regardless of gaps; rst asserted while locked -> all outputs 0 next cycle.
